// File: rtl/id_ex_skid_reg_if.sv
// Decode-to-execute handshake bundle for id_ex_skid_reg.
// The slave modport is the pipeline register; master is the decode/execute side.
interface id_ex_skid_reg_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int RIDX_W = 5,
   parameter int CTRL_W = 8
) ();
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [PC_W-1:0]   in_pc;
   logic [DATA_W-1:0] in_rs1;
   logic [DATA_W-1:0] in_rs2;
   logic [RIDX_W-1:0] in_rd;
   logic [DATA_W-1:0] in_imm;

   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [PC_W-1:0]   out_pc;
   logic [DATA_W-1:0] out_rs1;
   logic [DATA_W-1:0] out_rs2;
   logic [RIDX_W-1:0] out_rd;
   logic [DATA_W-1:0] out_imm;

   modport slave (
      input  in_valid, in_ctrl, in_pc, in_rs1, in_rs2, in_rd, in_imm,
      output in_ready,
      output out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_rd, out_imm,
      input  out_ready
   );

   modport master (
      output in_valid, in_ctrl, in_pc, in_rs1, in_rs2, in_rd, in_imm,
      input  in_ready,
      input  out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_rd, out_imm,
      output out_ready
   );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a two-entry skid buffer (M presented, S younger).
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_skid_reg #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int RIDX_W = 5,
   parameter int CTRL_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   id_ex_skid_reg_if.slave       bus
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int BUNDLE_W = CTRL_W + PC_W + (3 * DATA_W) + RIDX_W;

   // Encoding chosen so bit0 is m_valid and bit1 is s_valid directly.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b11
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_in_ready;
   logic                w_out_valid;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_load_m_in;
   logic                w_load_m_s;
   logic                w_load_s;
   logic [BUNDLE_W-1:0] w_in_bundle;
   logic [BUNDLE_W-1:0] r_m_bundle;
   logic [BUNDLE_W-1:0] r_s_bundle;

   assign w_out_valid = r_state[0];
   assign w_in_ready  = ~r_state[1];
   assign w_in_fire   = bus.in_valid & w_in_ready;
   assign w_out_fire  = w_out_valid & bus.out_ready;

   assign w_in_bundle = {bus.in_ctrl, bus.in_pc, bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_imm};

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign {bus.out_ctrl, bus.out_pc, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_imm} = r_m_bundle;

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next occupancy and entry load strobes; flush outranks every transfer.
   always_comb begin
      w_state_nxt = r_state;
      w_load_m_in = 1'b0;
      w_load_m_s  = 1'b0;
      w_load_s    = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_load_m_in = 1'b1;
                  w_state_nxt = ST_ONE;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_load_m_in = 1'b1;
                  w_state_nxt = ST_ONE;
               end else if (w_in_fire) begin
                  w_load_s    = 1'b1;
                  w_state_nxt = ST_TWO;
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end else begin
                  w_state_nxt = ST_ONE;
               end
            end
            ST_TWO: begin
               if (w_out_fire) begin
                  w_load_m_s  = 1'b1;
                  w_state_nxt = ST_ONE;
               end else begin
                  w_state_nxt = ST_TWO;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // Main entry payload: fresh input or promotion of the skid entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_bundle <= {BUNDLE_W{1'b0}};
      end else if (w_load_m_in) begin
         r_m_bundle <= w_in_bundle;
      end else if (w_load_m_s) begin
         r_m_bundle <= r_s_bundle;
      end else begin
         r_m_bundle <= r_m_bundle;
      end
   end

   // Skid entry payload, captured only when M is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_bundle <= {BUNDLE_W{1'b0}};
      end else if (w_load_s) begin
         r_s_bundle <= w_in_bundle;
      end else begin
         r_s_bundle <= r_s_bundle;
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   assign stall_cnt = r_stall_cnt;

   // Saturating count of cycles where execute refuses a valid bundle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= 16'h0000;
      end else if (flush) begin
         r_stall_cnt <= 16'h0000;
      end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'h0001;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed self-checking bench for id_ex_skid_reg.
// Stall counter scenario runs only when ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_skid_reg;
   localparam int DATA_W = 32;
   localparam int PC_W   = 32;
   localparam int RIDX_W = 5;
   localparam int CTRL_W = 8;
   localparam int BW     = CTRL_W + PC_W + (3 * DATA_W) + RIDX_W;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   id_ex_skid_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W), .RIDX_W(RIDX_W), .CTRL_W(CTRL_W)) bus ();

`ifdef ID_EX_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   id_ex_skid_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .RIDX_W(RIDX_W), .CTRL_W(CTRL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
`ifdef ID_EX_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // Payload fields are all derived from the PC so a whole bundle is checkable.
   function automatic logic [BW-1:0] exp_bundle(input logic [31:0] pc);
      logic [31:0] imm;
      imm = pc + 32'h1000_0000;
      return {pc[7:0] ^ 8'h3C, pc, ~pc, pc ^ 32'hA5A5_5A5A, pc[6:2], imm};
   endfunction

   function automatic logic [BW-1:0] obs_bundle();
      return {bus.out_ctrl, bus.out_pc, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_imm};
   endfunction

   task automatic drive(input logic [31:0] pc, input logic v);
      bus.in_valid = v;
      {bus.in_ctrl, bus.in_pc, bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_imm} = exp_bundle(pc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_ctrl   = 8'($urandom);
      bus.in_pc     = $urandom;
      bus.in_rs1    = $urandom;
      bus.in_rs2    = $urandom;
      bus.in_rd     = 5'($urandom);
      bus.in_imm    = $urandom;
      step();
      step();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_imm !== 32'h0) begin failures++; $display("FAIL reset_out_imm got=%h exp=0", bus.out_imm); end
      checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", bus.out_pc); end
      rst_n = 1'b1;
      bus.in_imm = 32'hFFFF_8000;
      bus.in_pc  = 32'h0000_0100;
      step();
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL first_out_valid got=%b exp=1", bus.out_valid); end
      checks++; if (bus.out_imm !== 32'hFFFF_8000) begin failures++; $display("FAIL first_out_imm got=%h exp=ffff8000", bus.out_imm); end
      checks++; if (bus.out_pc !== 32'h0000_0100) begin failures++; $display("FAIL first_out_pc got=%h exp=00000100", bus.out_pc); end
      bus.in_valid = 1'b0;
      step();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL first_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_streaming();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(32'(i * 4), 1'b1);
         step();
         checks++; if (obs_bundle() !== exp_bundle(32'(i * 4))) begin failures++; $display("FAIL stream_bundle[%0d] got=%h exp=%h", i, obs_bundle(), exp_bundle(32'(i * 4))); end
         checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, bus.out_valid); end
         checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      end
      bus.in_valid = 1'b0;
      step();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive(32'h40, 1'b1);
      step();
      checks++; if (bus.out_pc !== 32'h40) begin failures++; $display("FAIL bp_m_pc got=%h exp=40", bus.out_pc); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", bus.in_ready); end
      drive(32'h44, 1'b1);
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", bus.in_ready); end
      checks++; if (obs_bundle() !== exp_bundle(32'h40)) begin failures++; $display("FAIL bp_hold1 got=%h exp=%h", obs_bundle(), exp_bundle(32'h40)); end
      step();
      checks++; if (obs_bundle() !== exp_bundle(32'h40)) begin failures++; $display("FAIL bp_hold2 got=%h exp=%h", obs_bundle(), exp_bundle(32'h40)); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_hold got=%b exp=0", bus.in_ready); end
      bus.out_ready = 1'b1;
      step();
      checks++; if (obs_bundle() !== exp_bundle(32'h44)) begin failures++; $display("FAIL bp_skid_out got=%h exp=%h", obs_bundle(), exp_bundle(32'h44)); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_skid_valid got=%b exp=1", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", bus.in_ready); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      drive(32'h80, 1'b1);
      step();
      drive(32'h84, 1'b1);
      step();
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fl_full got=%b exp=0", bus.in_ready); end
      drive(32'h88, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fl_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL fl_in_ready got=%b exp=1", bus.in_ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.out_valid !== 1'b0 || bus.out_pc === 32'h88) begin failures++; $display("FAIL fl_leak[%0d] valid=%b pc=%h exp valid=0", i, bus.out_valid, bus.out_pc); end
      end
      drive(32'h8C, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fl_drop_empty got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      drive(32'hC0, 1'b1);
      step();
      drive(32'hC4, 1'b1);
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL ar_full valid=%b ready=%b exp 1/0", bus.out_valid, bus.in_ready); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL ar_out_pc got=%h exp=0", bus.out_pc); end
      #2;
      rst_n = 1'b1;
      step();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ar_after got=%b exp=0", bus.out_valid); end
   endtask

`ifdef ID_EX_STALL_CNT_EN
   task automatic test_stall_cnt();
      checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL sc_reset got=%h exp=0", stall_cnt); end
      bus.out_ready = 1'b0;
      drive(32'hE0, 1'b1);
      step();
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL sc_five got=%h exp=5", stall_cnt); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL sc_flush got=%h exp=0", stall_cnt); end
      drive(32'hE4, 1'b1);
      step();
      bus.in_valid = 1'b0;
      repeat (65535) @(posedge clk);
      #1;
      checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sc_reach_max got=%h exp=ffff", stall_cnt); end
      repeat (4) step();
      checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sc_saturate got=%h exp=ffff", stall_cnt); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL sc_flush_max got=%h exp=0", stall_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_async_reset();
`ifdef ID_EX_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the immediate sign-extender and decode logic.
- Captures one decoded instruction bundle per cycle: control word, PC, two register operands, destination index and the 32-bit extended immediate.
- Presents the bundle to the execute stage with a valid/ready handshake.
- Two-entry skid buffer (main M + skid S), so in_ready is a registered-state signal with no combinational path from out_ready. Supports synchronous flush for branch redirect.

Parameters:
- DATA_W, 32, width of operands and extended immediate
- PC_W, 32, program counter width
- RIDX_W, 5, register index width
- CTRL_W, 8, decoded control/opcode word width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush (branch taken / exception)
- in_valid  in  1  decode bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- in_ctrl  in  CTRL_W  decoded control word
- in_pc  in  PC_W  instruction PC
- in_rs1  in  DATA_W  operand A
- in_rs2  in  DATA_W  operand B
- in_rd  in  RIDX_W  destination register index
- in_imm  in  DATA_W  sign-extended immediate from extender
- out_valid  out  1  execute bundle valid
- out_ready  in  1  execute stage accepts bundle
- out_ctrl / out_pc / out_rs1 / out_rs2 / out_rd / out_imm  out  widths as inputs  registered bundle (entry M)

Behaviour:
- Reset (rst_n low, async): m_valid=0, s_valid=0, all M/S payload fields=0. Hence out_valid=0, all out_* = 0, in_ready=1. Release of reset is synchronous to clk (no accept in the release edge's cycle unless rst_n is already high at that edge).
- Definitions:
  - in_ready = !s_valid (pure function of registered state).
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = m_valid.
  - out_* driven from M.
- Latency: 1 cycle. A bundle accepted at edge N is visible on out_* after edge N.
- Per-edge update, priority top-down:
  - flush=1: m_valid=0, s_valid=0. Any in_fire in that cycle is dropped. Payload registers may hold old values.
  - s_valid=1 and out_fire: M<=S, s_valid=0. No input accept, since in_ready=0.
  - s_valid=0, in_fire, and (m_valid=0 or out_fire): M<=in, m_valid=1.
  - s_valid=0, in_fire, m_valid=1, out_fire=0: S<=in, s_valid=1 (skid capture; in_ready drops next cycle).
  - s_valid=0, no in_fire, out_fire: m_valid=0.
  - otherwise hold.
- Stall stability: while out_valid=1 and out_ready=0, all out_* remain bit-stable.
- Ordering: bundles leave strictly in acceptance order. S always holds the younger bundle.
- Full: s_valid=1 means in_ready=0. Decode must hold in_* stable.
- Empty: out_valid=0. out_* hold their last values; execute ignores them.
- Full throughput: with out_ready held at 1, one bundle per cycle with no bubbles; S is never used.
- No value transformation. Widths pass through unchanged, and in_imm is not re-extended.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN
- With macro defined:
  - Extra output port stall_cnt [15:0], reset to 0.
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on flush.
- Without macro: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and random in_* -> out_valid=0, in_ready=1, out_imm=0. Release, drive in_imm=32'hFFFF8000 and in_pc=32'h100 -> next cycle out_valid=1, out_imm=32'hFFFF8000, out_pc=32'h100.
- Streaming: out_ready=1, send 8 bundles with in_pc 0x0..0x1C, one per cycle -> out_pc sequence 0x0..0x1C on consecutive cycles; in_ready stays 1.
- Backpressure/skid:
  - Drop out_ready with M holding pc=0x40 while pc=0x44 is presented -> S captures 0x44, in_ready=0 next cycle, out_pc stays 0x40.
  - Raise out_ready -> 0x40 then 0x44 emitted in order, then in_ready=1.
- Flush: both entries full (pc 0x80, 0x84), assert flush with in_valid=1 and pc=0x88 -> next cycle out_valid=0, in_ready=1; 0x88 never appears on out_pc.
- Async reset mid-stall: M and S full, pull rst_n low between edges -> out_valid goes 0 and in_ready goes 1 immediately without waiting for a clock edge.
- With ID_EX_STALL_CNT_EN: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5; then flush -> stall_cnt=0. Preload near saturation -> stall_cnt stays at 16'hFFFF.
